// File: rtl/spi_slave_param_if.sv
// Core-side handshake bundle for spi_slave_param: transmit valid/ready, receive strobe, busy flag.
interface spi_slave_param_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output busy
    );

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy
    );
endinterface

// File: rtl/spi_slave_param.sv
// Oversampled SPI slave: all CPOL/CPHA modes, DATA_WIDTH-bit words, selectable bit order, back-to-back words.
// Defining SPI_SLAVE_FRAME_ERR_EN adds the frame_err pulse output (truncated word or transmit underrun).
module spi_slave_param #(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int LSB_FIRST  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic SCLK,
    input  logic CS,
    input  logic MOSI,
    output wire  MISO,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic frame_err,
`endif
    spi_slave_param_if.slave core
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam bit SAMPLE_ON_RISE = ((CPOL ^ CPHA) == 0);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    // Pin synchronisers are deliberately not reset: a CS held low through reset
    // must not look like a fresh falling edge afterwards.
    logic [2:0] pin_in;
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    logic [1:0] dly_reg;

    assign pin_in = {MOSI, CS, SCLK};

    always_ff @(posedge clk) begin
        meta_reg <= pin_in;
        sync_reg <= meta_reg;
        dly_reg  <= sync_reg[1:0];
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_sync, mosi_sync;
    logic sample_edge, shift_edge;

    assign sclk_rise   = sync_reg[0] & ~dly_reg[0];
    assign sclk_fall   = ~sync_reg[0] & dly_reg[0];
    assign cs_fall     = ~sync_reg[1] & dly_reg[1];
    assign cs_rise     = sync_reg[1] & ~dly_reg[1];
    assign cs_sync     = sync_reg[1];
    assign mosi_sync   = sync_reg[2];
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] shift_tx_reg, shift_tx_next;
    logic [DATA_WIDTH-1:0] shift_rx_reg, shift_rx_next;
    logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
    logic                  rx_valid_reg, rx_valid_next;
    logic                  load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_tx_reg <= '0;
            shift_rx_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_tx_reg <= shift_tx_next;
            shift_rx_reg <= shift_rx_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_tx_next = shift_tx_reg;
        shift_rx_next = shift_rx_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        load          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (cnt_reg == CNT_FULL) begin
                        rx_data_next  = shift_rx_reg;
                        rx_valid_next = 1'b1;
                    end
                end else if (cnt_reg == CNT_FULL) begin
                    rx_data_next  = shift_rx_reg;
                    rx_valid_next = 1'b1;
                    load          = 1'b1;
                end else begin
                    if (sample_edge) begin
                        if (LSB_FIRST != 0)
                            shift_rx_next = {mosi_sync, shift_rx_reg[DATA_WIDTH-1:1]};
                        else
                            shift_rx_next = {shift_rx_reg[DATA_WIDTH-2:0], mosi_sync};
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    // With no bit sampled yet in this word, the shift edge is either the
                    // trailing edge of the previous word or the CPHA=1 presenting edge.
                    if (shift_edge && cnt_reg != '0) begin
                        if (LSB_FIRST != 0)
                            shift_tx_next = {1'b0, shift_tx_reg[DATA_WIDTH-1:1]};
                        else
                            shift_tx_next = {shift_tx_reg[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            shift_tx_next = core.tx_valid ? core.tx_data : '0;
            cnt_next      = '0;
        end
    end

    logic miso_bit, miso_oe;
    assign miso_bit = (LSB_FIRST != 0) ? shift_tx_reg[0] : shift_tx_reg[DATA_WIDTH-1];
    assign miso_oe  = (state_reg == ACTIVE) && !cs_sync && !reset;
    assign MISO     = miso_oe ? miso_bit : 1'bz;

    assign core.tx_ready = load && core.tx_valid && !reset;
    assign core.rx_data  = rx_data_reg;
    assign core.rx_valid = rx_valid_reg;
    assign core.busy     = (state_reg == ACTIVE);

`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = !reset && ((load && !core.tx_valid) ||
                       (state_reg == ACTIVE && cs_rise && cnt_reg != '0 && cnt_reg != CNT_FULL));
`endif
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: three configurations (mode 0 LSB-first, mode 3 MSB-first, 16-bit mode 1)
// driven by a bit-banged SPI master; vector table plus hand-written multi-word and reset sequences.
module tb_spi_slave_param;
    localparam int H = 8;  // SCLK half period in clk cycles

    logic clk = 1'b0;
    logic reset;
    logic sclk [3];
    logic cs   [3];
    logic mosi [3];
    wire  miso0, miso1, miso2;
    pullup (miso0);
    pullup (miso1);
    pullup (miso2);

    spi_slave_param_if #(.DATA_WIDTH(8))  if0 ();
    spi_slave_param_if #(.DATA_WIDTH(8))  if1 ();
    spi_slave_param_if #(.DATA_WIDTH(16)) if2 ();

`ifdef SPI_SLAVE_FRAME_ERR_EN
    wire fe0, fe1, fe2;
`endif

    spi_slave_param #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(1)) u0 (
        .clk(clk), .reset(reset), .SCLK(sclk[0]), .CS(cs[0]), .MOSI(mosi[0]), .MISO(miso0),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err(fe0),
`endif
        .core(if0));
    spi_slave_param #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(0)) u1 (
        .clk(clk), .reset(reset), .SCLK(sclk[1]), .CS(cs[1]), .MOSI(mosi[1]), .MISO(miso1),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err(fe1),
`endif
        .core(if1));
    spi_slave_param #(.DATA_WIDTH(16), .CPOL(0), .CPHA(1), .LSB_FIRST(1)) u2 (
        .clk(clk), .reset(reset), .SCLK(sclk[2]), .CS(cs[2]), .MOSI(mosi[2]), .MISO(miso2),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err(fe2),
`endif
        .core(if2));

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int rxv_cnt [3] = '{0, 0, 0};
    int txr_cnt [3] = '{0, 0, 0};
    int fe_cnt  [3] = '{0, 0, 0};

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (if0.rx_valid === 1'b1) rxv_cnt[0] <= rxv_cnt[0] + 1;
        if (if1.rx_valid === 1'b1) rxv_cnt[1] <= rxv_cnt[1] + 1;
        if (if2.rx_valid === 1'b1) rxv_cnt[2] <= rxv_cnt[2] + 1;
        if (if0.tx_ready === 1'b1) txr_cnt[0] <= txr_cnt[0] + 1;
        if (if1.tx_ready === 1'b1) txr_cnt[1] <= txr_cnt[1] + 1;
        if (if2.tx_ready === 1'b1) txr_cnt[2] <= txr_cnt[2] + 1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (fe0 === 1'b1) fe_cnt[0] <= fe_cnt[0] + 1;
        if (fe1 === 1'b1) fe_cnt[1] <= fe_cnt[1] + 1;
        if (fe2 === 1'b1) fe_cnt[2] <= fe_cnt[2] + 1;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic miso_of(input int d);
        case (d)
            0: return miso0;
            1: return miso1;
            default: return miso2;
        endcase
    endfunction

    function automatic logic [31:0] rx_of(input int d);
        case (d)
            0: return 32'(if0.rx_data);
            1: return 32'(if1.rx_data);
            default: return 32'(if2.rx_data);
        endcase
    endfunction

    function automatic logic busy_of(input int d);
        case (d)
            0: return if0.busy;
            1: return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    task automatic set_tx(input int d, input logic v, input logic [31:0] data);
        case (d)
            0: begin if0.tx_valid = v; if0.tx_data = data[7:0];  end
            1: begin if1.tx_valid = v; if1.tx_data = data[7:0];  end
            default: begin if2.tx_valid = v; if2.tx_data = data[15:0]; end
        endcase
    endtask

    // Bit-banged master for one word (or the first nbits of one); cap holds MISO at each sample.
    task automatic spi_word(input int d, input int nbits, input logic [31:0] mo, output logic [31:0] cap);
        int w, idx;
        logic pol, pha, lsb;
        w   = (d == 2) ? 16 : 8;
        pol = (d == 1);
        pha = (d != 0);
        lsb = (d != 1);
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : w - 1 - i;
            if (!pha) begin
                mosi[d] = mo[idx];
                wait_clks(H);
                sclk[d] = ~pol;
                cap[idx] = miso_of(d);
                wait_clks(H);
                sclk[d] = pol;
            end else begin
                sclk[d] = ~pol;
                mosi[d] = mo[idx];
                wait_clks(H);
                sclk[d] = pol;
                cap[idx] = miso_of(d);
                wait_clks(H);
            end
        end
        if (!pha) wait_clks(H);
    endtask

    typedef struct {
        int          dut;
        logic        tv;
        logic [31:0] tx;
        logic [31:0] mo;
        int          nbits;
        logic [31:0] exp_rx;
        logic [31:0] exp_cap;
        int          exp_rxv;
        int          exp_txr;
        int          exp_fe;
    } vec_t;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [4];
        logic [31:0] cap, cap2;
        int d, rx0, tr0, fe0_s;

        // exp_fe: the reload after a completed word finds tx_valid low, which counts as underrun.
        tbl[0] = '{0, 1'b1, 32'hA5,   32'h3C,   8,  32'h3C,   32'hA5,   1, 1, 1};
        tbl[1] = '{0, 1'b1, 32'hC3,   32'hFF,   5,  32'h3C,   32'h03,   0, 1, 1};
        tbl[2] = '{0, 1'b0, 32'h5A,   32'h96,   8,  32'h96,   32'h00,   1, 0, 2};
        tbl[3] = '{2, 1'b1, 32'h1234, 32'hBEEF, 16, 32'hBEEF, 32'h1234, 1, 1, 1};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cs[i] = 1'b1;
            mosi[i] = 1'b0;
            sclk[i] = (i == 1);
            set_tx(i, 1'b0, 32'h0);
        end
        wait_clks(5);
        reset = 1'b0;
        wait_clks(2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_rx_data%0d", i), rx_of(i), 32'h0);
            check($sformatf("reset_busy%0d", i), 32'(busy_of(i)), 32'h0);
            check($sformatf("reset_miso_released%0d", i), 32'(miso_of(i)), 32'h1);
        end
        check("reset_rx_valid", 32'(rxv_cnt[0] + rxv_cnt[1] + rxv_cnt[2]), 32'h0);
        check("reset_tx_ready", 32'(txr_cnt[0] + txr_cnt[1] + txr_cnt[2]), 32'h0);

        for (int v = 0; v < 4; v++) begin
            d = tbl[v].dut;
            rx0 = rxv_cnt[d];
            tr0 = txr_cnt[d];
            fe0_s = fe_cnt[d];
            set_tx(d, tbl[v].tv, tbl[v].tx);
            cs[d] = 1'b0;
            wait_clks(6);
            check($sformatf("v%0d_busy_active", v), 32'(busy_of(d)), 32'h1);
            set_tx(d, 1'b0, tbl[v].tx);
            wait_clks(H);
            spi_word(d, tbl[v].nbits, tbl[v].mo, cap);
            cs[d] = 1'b1;
            wait_clks(3);
            check($sformatf("v%0d_miso_released", v), 32'(miso_of(d)), 32'h1);
            wait_clks(4);
            check($sformatf("v%0d_busy_idle", v), 32'(busy_of(d)), 32'h0);
            check($sformatf("v%0d_rx_data", v), rx_of(d), tbl[v].exp_rx);
            check($sformatf("v%0d_miso_word", v), cap, tbl[v].exp_cap);
            check($sformatf("v%0d_rx_valid_pulses", v), 32'(rxv_cnt[d] - rx0), 32'(tbl[v].exp_rxv));
            check($sformatf("v%0d_tx_ready_pulses", v), 32'(txr_cnt[d] - tr0), 32'(tbl[v].exp_txr));
`ifdef SPI_SLAVE_FRAME_ERR_EN
            check($sformatf("v%0d_frame_err_pulses", v), 32'(fe_cnt[d] - fe0_s), 32'(tbl[v].exp_fe));
`endif
            $display("vec %0d: dut %0d bits %0d mosi=%h rx=%h miso=%h", v, d, tbl[v].nbits, tbl[v].mo, rx_of(d), cap);
        end

        // Mode 3, MSB first, two words in one frame.
        rx0 = rxv_cnt[1];
        tr0 = txr_cnt[1];
        set_tx(1, 1'b1, 32'h81);
        cs[1] = 1'b0;
        wait_clks(6);
        set_tx(1, 1'b1, 32'h7E);
        wait_clks(H);
        spi_word(1, 8, 32'hF0, cap);
        set_tx(1, 1'b0, 32'h7E);
        check("b2b_rx_word1", rx_of(1), 32'hF0);
        check("b2b_rx_pulses_word1", 32'(rxv_cnt[1] - rx0), 32'd1);
        spi_word(1, 8, 32'h0F, cap2);
        cs[1] = 1'b1;
        wait_clks(7);
        check("b2b_rx_word2", rx_of(1), 32'h0F);
        check("b2b_rx_pulses", 32'(rxv_cnt[1] - rx0), 32'd2);
        check("b2b_miso_word1", cap, 32'h81);
        check("b2b_miso_word2", cap2, 32'h7E);
        check("b2b_tx_ready_pulses", 32'(txr_cnt[1] - tr0), 32'd2);
        $display("b2b: mode 3 rx=F0,0F expected, miso words %h %h", cap, cap2);

        // Reset one clk after the 3rd SCLK edge with CS held low.
        rx0 = rxv_cnt[0];
        set_tx(0, 1'b1, 32'hAA);
        cs[0] = 1'b0;
        wait_clks(6);
        set_tx(0, 1'b0, 32'hAA);
        wait_clks(H);
        mosi[0] = 1'b1;
        wait_clks(H);
        sclk[0] = 1'b1;
        wait_clks(H);
        sclk[0] = 1'b0;
        mosi[0] = 1'b0;
        wait_clks(H);
        sclk[0] = 1'b1;
        wait_clks(4);
        reset = 1'b1;
        #1;
        check("rst_miso_released_during", 32'(miso0), 32'h1);
        wait_clks(1);
        reset = 1'b0;
        wait_clks(1);
        check("rst_busy", 32'(if0.busy), 32'h0);
        check("rst_rx_data", rx_of(0), 32'h0);
        check("rst_miso_released", 32'(miso0), 32'h1);
        check("rst_tx_ready", 32'(if0.tx_ready), 32'h0);
        wait_clks(H);
        sclk[0] = 1'b0;
        spi_word(0, 8, 32'hFF, cap);
        check("rst_ignored_busy", 32'(if0.busy), 32'h0);
        check("rst_ignored_no_rx", 32'(rxv_cnt[0] - rx0), 32'd0);
        cs[0] = 1'b1;
        wait_clks(H);
        set_tx(0, 1'b1, 32'h0F);
        cs[0] = 1'b0;
        wait_clks(6);
        set_tx(0, 1'b0, 32'h0F);
        wait_clks(H);
        spi_word(0, 8, 32'h55, cap);
        cs[0] = 1'b1;
        wait_clks(7);
        check("rst_next_rx", rx_of(0), 32'h55);
        check("rst_next_miso", cap, 32'h0F);
        check("rst_next_rx_pulses", 32'(rxv_cnt[0] - rx0), 32'd1);
        $display("reset: frame after reset rx=%h miso=%h", rx_of(0), cap);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised successor to the team's bit-serial SPI slave, clocked entirely from one system clock.
- SCLK, CS and MOSI are oversampled and synchronised to clk, not used as clocks.
- Supports all four CPOL/CPHA modes, configurable word width and bit order, and multiple back-to-back words per CS assertion.
- Adds a valid/ready transmit handshake and a receive strobe to the core-side logic.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (2..32).
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- LSB_FIRST, 1, 1 = bit 0 shifted first (matches the previous generation), 0 = MSB first.

Ports:
- clk, input, 1, system clock; SCLK frequency must be at most clk/4.
- reset, input, 1, synchronous, active-high.
- SCLK, input, 1, SPI serial clock from the master (asynchronous).
- CS, input, 1, active-low chip select (asynchronous).
- MOSI, input, 1, master-out data (asynchronous).
- MISO, output, 1, slave-out data; high-Z whenever the internal CS is high or reset is asserted.
- tx_data, input, DATA_WIDTH, word to transmit next.
- tx_valid, input, 1, tx_data holds a word.
- tx_ready, output, 1, one-cycle pulse: tx_data was consumed this cycle.
- rx_data, output, DATA_WIDTH, last complete received word; held until the next word completes.
- rx_valid, output, 1, one-cycle pulse when rx_data updates.
- busy, output, 1, high while a frame is in progress (state ACTIVE).

Behaviour:
- Reset values:
  - MISO = Z; tx_ready = 0; rx_valid = 0; rx_data = 0; busy = 0.
  - State = IDLE; bit counter = 0.
- Synchronisers and edge detect:
  - SCLK, CS and MOSI each pass through a 2-flop synchroniser.
  - SCLK edges come from a third registered copy; cs_fall and cs_rise likewise.
  - sample_edge is the rising synchronised SCLK edge when CPOL^CPHA = 0, otherwise the falling edge.
  - shift_edge is the opposite edge.
- State IDLE:
  - MISO = Z.
  - On cs_fall, go to ACTIVE and perform a load.
- Load:
  - If tx_valid = 1, shift_tx <= tx_data and tx_ready pulses in that same cycle.
  - Otherwise shift_tx <= all zeros and tx_ready stays 0 (underrun).
  - Bit counter <= 0.
- State ACTIVE:
  - MISO drives the current output bit: shift_tx[0] if LSB_FIRST, else shift_tx[DATA_WIDTH-1].
  - CPHA = 0: the first bit is on MISO from the load cycle onward; each shift_edge advances the bit.
  - CPHA = 1: the first shift_edge presents bit 0 and no advance occurs before it.
  - Each sample_edge shifts the synchronised MOSI into shift_rx in the configured order and increments the bit counter.
- Word completion:
  - When the bit counter reaches DATA_WIDTH on a sample_edge, the next cycle sets rx_data <= shift_rx and pulses rx_valid.
  - A new load occurs (back-to-back words) with the counter cleared.
  - The MISO bit for word n+1 is valid before the master's next sample_edge.
- cs_rise in ACTIVE:
  - Go to IDLE; MISO = Z.
  - A partial word is discarded: no rx_valid, counter cleared.
  - Takes priority over any edge detected in the same cycle.
- Simultaneous events: when cs_fall and reset occur in the same cycle, reset wins.
- Reset mid-frame:
  - All outputs return to reset values.
  - The block ignores SCLK until the next cs_fall; a still-low CS after reset does not start a frame.
- tx_ready never asserts outside a load cycle.
- A tx_data change while tx_valid is low is ignored.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - Pulses for one cycle on cs_rise when the bit counter is nonzero (truncated word).
  - Pulses for one cycle at a load with tx_valid = 0 (underrun).
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Mode 0, LSB_FIRST = 1, DATA_WIDTH = 8, tx_data = 8'hA5 valid before CS falls; master sends 8'h3C:
  - MISO shows 1,0,1,0,0,1,0,1.
  - rx_data = 8'h3C with one rx_valid pulse.
  - Exactly one tx_ready pulse.
- Mode 3, LSB_FIRST = 0, two words in one CS; tx 8'h81 then 8'h7E, master sends 8'hF0 then 8'h0F:
  - Two rx_valid pulses carrying F0 then 0F.
  - MISO MSB-first 81 then 7E.
  - Two tx_ready pulses.
- CS deasserted after 5 SCLK cycles:
  - No rx_valid; rx_data keeps its prior value.
  - MISO = Z within 3 clk cycles.
  - With SPI_SLAVE_FRAME_ERR_EN, frame_err pulses once.
- tx_valid = 0 at CS fall:
  - MISO outputs 8'h00 and tx_ready stays 0.
  - With SPI_SLAVE_FRAME_ERR_EN, frame_err pulses.
- reset asserted for 1 clk after the 3rd SCLK edge, CS kept low:
  - All outputs return to reset values and no rx_valid occurs.
  - The next full CS-framed transfer of 8'h55 receives correctly.
- DATA_WIDTH = 16, mode 1, master sends 16'hBEEF, tx 16'h1234:
  - rx_data = 16'hBEEF.
  - Master captures 16'h1234.
